busmux_arb2: RTL
================

# busmux_arb2

Two-master, round-robin bus arbiter that sits directly upstream of the register slaves on the busmux register bus. It accepts single-beat read/write requests from two masters and serializes them onto one slave port (we/addr/wdata out, rdata in). It also returns the slave's read data and a one-cycle ack to the granted master. The slave port assumes a slave with synchronous write and a registered read that is valid one cycle after the address.

## Interface

Parameters:
- DATAW, 8, data width of master and slave data buses
- ADDRW, 8, address width

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_m0_req  in  1  master 0 request; held with fields stable until o_m0_ack
- i_m0_we  in  1  master 0: 1 = write, 0 = read
- i_m0_addr  in  ADDRW  master 0 address
- i_m0_wdata  in  DATAW  master 0 write data
- o_m0_ack  out  1  one-cycle completion pulse to master 0
- o_m0_rdata  out  DATAW  read data, valid in o_m0_ack cycle
- i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, o_m1_ack, o_m1_rdata: same as master 0
- o_s_we  out  1  slave write strobe, exactly one cycle per write
- o_s_addr  out  ADDRW  slave address
- o_s_wdata  out  DATAW  slave write data
- i_s_rdata  in  DATAW  slave registered read data, valid one cycle after o_s_addr

## Operation

- FSM states: IDLE, ISSUE, CAPT, DONE. The sequence is fixed: IDLE -> ISSUE -> CAPT -> DONE -> IDLE.
- IDLE:
  - If any request is pending, arbitrate and register the winner's we/addr/wdata into the slave-port registers.
  - Record the grant index and go to ISSUE. Otherwise stay in IDLE.
- Arbitration:
  - Single requester wins.
  - If both request, grant the master other than last-granted pointer lp.
  - Update lp to the winner on every grant. lp resets to 1, so m0 wins the first tie.
- ISSUE:
  - o_s_addr and o_s_wdata are driven.
  - o_s_we = we_q AND i_rst_n.
  - The slave samples at the end of this cycle.
- CAPT: i_s_rdata is captured into the granted master's rdata register. It is captured for writes too; that value is unspecified for writes and must not be checked.
- DONE:
  - The granted master's ack register is 1, and its rdata is valid.
  - No arbitration takes place. The master may change its fields or request on the edge ending DONE.
- o_s_addr and o_s_wdata hold their value until the next grant. o_s_we is 0 in every state except ISSUE.
- A master dropping req before its ack is a protocol violation. The transaction still completes and acks.
- The non-granted master's ack stays 0. Its rdata register holds its previous value.
- Reset values: state IDLE, lp=1, every o_* = 0.

## Timing

- A request first seen high in IDLE at cycle T gives:
  - ISSUE at T+1 (o_s_we high only for writes)
  - CAPT at T+2
  - ack high in T+3 only
- The earliest next ISSUE is T+5. Peak throughput is one transaction per 4 cycles.
- A master holding req high continuously is regranted in the IDLE cycle after DONE, subject to round-robin.
- Reset mid-transaction:
  - i_rst_n low in any cycle forces o_s_we to 0 in that cycle.
  - All state returns to reset values at the edge, and no ack is produced for the aborted transaction.
- Width rules: no arithmetic; all data and addresses pass through unmodified at DATAW and ADDRW.

## Structure

- Package busmux_pkg:
  - state enum (IDLE, ISSUE, CAPT, DONE)
  - 1-bit master-index type
  - localparam NMASTERS = 2
- Sub-module rr_arb2: combinational two-request round-robin pick plus the registered lp pointer. Ports: clk, rst_n, req[1:0], grant_en, gnt_idx, gnt_valid.
- The FSM, slave-port registers and per-master rdata/ack registers live in busmux_arb2.

## Test plan

Bench: busmux_arb2 driving a three-register slave with DATAW=8, slave reset tied to !i_rst_n.

- **Reset:** hold i_rst_n=0 for 3 cycles with both reqs high -> all outputs 0. After release, first ISSUE comes two cycles later with the m0 fields.
- **Single write:** m0 writes addr 0x01, data 0xA5, req seen at T -> o_s_we=1 only at T+1 with o_s_addr=0x01, o_s_wdata=0xA5. o_m0_ack=1 only at T+3; o_m1_ack stays 0.
- **Readback:** after that write, m1 reads addr 0x01 -> o_m1_ack at T+3 with o_m1_rdata=0xA5, and o_s_we stays 0 throughout.
- **Tie and fairness:** both masters hold req with writes m0 -> addr 0x00 and m1 -> addr 0x02 for 4 transactions -> grant order m0, m1, m0, m1. ISSUE cycles are 4 apart, and acks alternate.
- **Back-to-back:** m0 alone writes 0x10, 0x20, 0x30 to addrs 0, 1, 2 with req held high -> acks exactly 4 cycles apart. Reads of addrs 0, 1, 2 then return 0x10, 0x20, 0x30.
- **Reset mid-op:** drive i_rst_n=0 during the ISSUE cycle of a write of 0xFF to addr 0 -> o_s_we=0 in that cycle, no ack follows, and a later read of addr 0 returns 0x00.

Source files
------------

// File: rtl/busmux_pkg.sv
// Shared types for the busmux register-bus arbiter: FSM state encoding,
// master index type and master count.
package busmux_pkg;

    localparam int NMASTERS = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT,
        DONE
    } state_t;

    typedef logic midx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin pick with a registered last-granted pointer.
// On a tie the master other than the last winner is chosen.
module rr_arb2
    import busmux_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    midx_t lp_q;
    midx_t lp_d;

    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = req[1];
        if (&req) begin
            gnt_idx = ~lp_q;
        end
        lp_d = lp_q;
        if (grant_en && gnt_valid) begin
            lp_d = gnt_idx;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values; the reset is synchronous to clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lp_q <= 1'b1;
        end else begin
            lp_q <= lp_d;
        end
    end

endmodule

// File: rtl/busmux_arb2.sv
// Two-master round-robin arbiter serializing single-beat requests onto one
// register-slave port with a registered one-cycle read latency.
module busmux_arb2
    import busmux_pkg::*;
#(
    parameter int DATAW = 8,
    parameter int ADDRW = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_m0_req,
    input  logic             i_m0_we,
    input  logic [ADDRW-1:0] i_m0_addr,
    input  logic [DATAW-1:0] i_m0_wdata,
    output logic             o_m0_ack,
    output logic [DATAW-1:0] o_m0_rdata,
    input  logic             i_m1_req,
    input  logic             i_m1_we,
    input  logic [ADDRW-1:0] i_m1_addr,
    input  logic [DATAW-1:0] i_m1_wdata,
    output logic             o_m1_ack,
    output logic [DATAW-1:0] o_m1_rdata,
    output logic             o_s_we,
    output logic [ADDRW-1:0] o_s_addr,
    output logic [DATAW-1:0] o_s_wdata,
    input  logic [DATAW-1:0] i_s_rdata
);

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDRW-1:0]      addr_q, addr_d;
    logic [DATAW-1:0]      wdata_q, wdata_d;
    midx_t                 gnt_q, gnt_d;
    logic [NMASTERS-1:0]   ack_q, ack_d;
    logic [DATAW-1:0]      rdata0_q, rdata0_d;
    logic [DATAW-1:0]      rdata1_q, rdata1_d;

    logic                  gnt_idx;
    logic                  gnt_valid;

    rr_arb2 u_arb (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .req       ({i_m1_req, i_m0_req}),
        .grant_en  (state_q == IDLE),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    we_d    = gnt_idx ? i_m1_we    : i_m0_we;
                    addr_d  = gnt_idx ? i_m1_addr  : i_m0_addr;
                    wdata_d = gnt_idx ? i_m1_wdata : i_m0_wdata;
                    gnt_d   = gnt_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                // Slave read data is valid now; the ack register fires in DONE.
                if (gnt_q) begin
                    rdata1_d = i_s_rdata;
                end else begin
                    rdata0_d = i_s_rdata;
                end
                ack_d   = gnt_q ? 2'b10 : 2'b01;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= 1'b0;
            ack_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Reset gates the strobe combinationally so an aborted write never lands.
    assign o_s_we     = we_q & (state_q == ISSUE) & i_rst_n;
    assign o_s_addr   = addr_q;
    assign o_s_wdata  = wdata_q;
    assign o_m0_ack   = ack_q[0];
    assign o_m1_ack   = ack_q[1];
    assign o_m0_rdata = rdata0_q;
    assign o_m1_rdata = rdata1_q;

endmodule
